fifo_rptr_empty: RTL and testbench
==================================

// Module: fifo_rptr_empty
// PURPOSE
//  Read-side pointer and flag controller of the async FIFO; pairs with the write-side pointer/full logic.
//  Brings the Gray write pointer into the rclk domain through two flops.
//  Keeps the binary and Gray read pointers, and generates empty, almost-empty and a pessimistic fill level.
//  Drives the dual-port RAM read address. Exports the Gray read pointer for synchronisation into the write domain.
// PARAMETERS
//  width      8  address bits; RAM depth = 2**width; pointers are width+1 bits (extra wrap bit)
//  AE_THRESH  2  ralmost_empty asserts when rlevel <= AE_THRESH
// PORTS
//  rclk           in   1        read-domain clock; the only clock
//  rrst           in   1        synchronous active-high reset, sampled on rising rclk
//  rinc           in   1        read request; honoured only when rempty=0
//  wptr           in   width+1  Gray write pointer, asynchronous (write domain)
//  raddr          out  width    RAM read address = rbin[width-1:0]
//  rptr           out  width+1  registered Gray read pointer, to write domain
//  rempty         out  1        registered empty flag
//  ralmost_empty  out  1        registered, rlevel <= AE_THRESH
//  rlevel         out  width+1  registered occupancy as seen from the read domain (0..2**width)
// BEHAVIOUR
//  Clock and reset
//   - One clock (rclk). Reset is synchronous, active-high, and is checked before any other action.
//   - Reset values: rq1_wptr=0, rq2_wptr=0, rbin=0, rptr=0, raddr=0, rlevel=0, rempty=1, ralmost_empty=1.
//  Write-pointer synchroniser
//   - 2 flops: rq1_wptr <= wptr; rq2_wptr <= rq1_wptr. No other logic on the wptr path.
//  Read pointer
//   - rd_en   = rinc & ~rempty.
//   - rbin_nx = rbin + rd_en, modulo 2**(width+1).
//   - rgray_nx = (rbin_nx >> 1) ^ rbin_nx.
//   - Each edge: rbin <= rbin_nx and rptr <= rgray_nx.
//   - rinc while rempty=1 is ignored: no pointer move (underflow guard).
//  Flags and level, all registered from _nx values
//   - rempty <= (rgray_nx == rq2_wptr).
//   - rlevel <= gray2bin(rq2_wptr) - rbin_nx, modulo 2**(width+1).
//   - ralmost_empty <= (level_nx <= AE_THRESH).
//  Latency
//   - wptr change to rempty deassert: 3 rclk edges (2 sync + 1 flag register).
//   - Accepted read: raddr/rptr update on the same edge that samples rinc; rempty can assert on that same edge.
//   - rempty deassertion is pessimistic (late) and never early. Data is read combinationally at raddr while rempty=0.
//  Boundaries
//   - Wrap: rbin rolls from 2**(width+1)-1 to 0; raddr rolls 2**width-1 to 0 and the MSB toggles.
//     Empty compare uses all width+1 bits, so full vs empty is unambiguous.
//   - Simultaneous last read and new write arrival in rq2_wptr: rempty stays 0; rlevel unchanged.
//   - Reset during a read: rinc is ignored that cycle and all state returns to reset values.
//     The write side must be reset in the same window; otherwise pointer mismatch is undefined at system level.
// STRUCTURE
//  Shared package (fifo_pkg)
//   - bin2gray and gray2bin functions; defaults for width and AE_THRESH.
//  Sub-module
//   - synchronizer_r: 2-flop, width+1 bits, rclk/rrst, wptr -> rq2_wptr, reset to 0.
//   - Everything else lives in this module's single always block plus combinational _nx logic.
// TESTING  (width=3, AE_THRESH=2)
//  1. rrst=1 for 2 cycles -> rempty=1, ralmost_empty=1, rptr=0, raddr=0, rlevel=0.
//  2. wptr=0, rinc=1 for 5 cycles -> rptr/raddr stay 0, rempty stays 1.
//  3. wptr 0->4'b0001 at edge t -> rempty=0 and rlevel=1 at t+3; then rinc pulse ->
//     next edge raddr=1, rptr=4'b0001, rempty=1, rlevel=0.
//  4. wptr=4'b1100 (8 written), rinc held 8 cycles -> raddr 0..7 then 0, rlevel 8..0,
//     rptr ends 4'b1100, rempty=1 after 8th read, further rinc ignored.
//  5. rlevel=1 and rq2_wptr advances to level 2 in the same cycle as rinc -> rempty stays 0, rlevel stays 1.
//  6. rlevel=5, rrst=1 with rinc=1 -> next edge: all outputs at reset values, rbin not incremented.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic.
// Gray/binary conversion on a 32-bit word; callers size-cast the result.
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH_DEF = 8;
    localparam int unsigned AE_THRESH_DEF  = 2;

    typedef logic [31:0] ptr_word_t;

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return (b >> 1) ^ b;
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/synchronizer_r.sv
// Two-flop synchroniser bringing the Gray write pointer into rclk.
// Plain flops only; the Gray code keeps multi-bit capture safe.
module synchronizer_r #(
    parameter int unsigned W = 9
) (
    input  logic         rclk,
    input  logic         rrst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q1_q;
    logic [W-1:0] q2_q;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            q1_q <= '0;
            q2_q <= '0;
        end else begin
            q1_q <= d;
            q2_q <= q1_q;
        end
    end

    assign q = q2_q;

endmodule

// File: rtl/fifo_rptr_empty.sv
// Read-side pointer, empty/almost-empty flags and fill level of the async FIFO.
// All flags are registered from next-state pointer values.
module fifo_rptr_empty
    import fifo_pkg::*;
#(
    parameter int unsigned width     = FIFO_WIDTH_DEF,
    parameter int unsigned AE_THRESH = AE_THRESH_DEF
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rinc,
    input  logic [width:0]   wptr,
    output logic [width-1:0] raddr,
    output logic [width:0]   rptr,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [width:0]   rlevel
);

    localparam int unsigned PTR_W = width + 1;

    logic [width:0] rq2_wptr;
    logic [width:0] rq2_bin;
    logic [width:0] rbin_q, rbin_d;
    logic [width:0] rptr_q, rptr_d;
    logic [width:0] rlevel_q, rlevel_d;
    logic           rempty_q, rempty_d;
    logic           rae_q, rae_d;
    logic           rd_en;

    synchronizer_r #(.W(PTR_W)) u_sync (
        .rclk (rclk),
        .rrst (rrst),
        .d    (wptr),
        .q    (rq2_wptr)
    );

    assign rq2_bin = PTR_W'(gray2bin(ptr_word_t'(rq2_wptr)));

    always_comb begin
        rd_en    = rinc & ~rempty_q;
        rbin_d   = rbin_q + PTR_W'(rd_en);
        rptr_d   = PTR_W'(bin2gray(ptr_word_t'(rbin_d)));
        rempty_d = (rptr_d == rq2_wptr);
        // Level uses the already-synchronised write pointer, so it can only lag.
        rlevel_d = rq2_bin - rbin_d;
        rae_d    = (ptr_word_t'(rlevel_d) <= AE_THRESH);
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin_q   <= '0;
            rptr_q   <= '0;
            rlevel_q <= '0;
            rempty_q <= 1'b1;
            rae_q    <= 1'b1;
        end else begin
            rbin_q   <= rbin_d;
            rptr_q   <= rptr_d;
            rlevel_q <= rlevel_d;
            rempty_q <= rempty_d;
            rae_q    <= rae_d;
        end
    end

    assign raddr         = rbin_q[width-1:0];
    assign rptr          = rptr_q;
    assign rempty        = rempty_q;
    assign ralmost_empty = rae_q;
    assign rlevel        = rlevel_q;

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Directed bench for fifo_rptr_empty (width=3, AE_THRESH=2).
// Driver queues hand-computed expectations; a monitor pops and compares them.
module tb_fifo_rptr_empty;

    logic       rclk;
    logic       rrst;
    logic       rinc;
    logic [3:0] wptr;
    logic [2:0] raddr;
    logic [3:0] rptr;
    logic       rempty;
    logic       ralmost_empty;
    logic [3:0] rlevel;

    fifo_rptr_empty #(.width(3), .AE_THRESH(2)) dut (
        .rclk          (rclk),
        .rrst          (rrst),
        .rinc          (rinc),
        .wptr          (wptr),
        .raddr         (raddr),
        .rptr          (rptr),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .rlevel        (rlevel)
    );

    typedef struct {
        int         cyc;
        string      nm;
        logic       e;
        logic       ae;
        logic [3:0] p;
        logic [2:0] a;
        logic [3:0] l;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    always @(posedge rclk) cyc <= cyc + 1;

    // Monitor: compare outputs at the falling edge against queued expectations.
    initial begin
        exp_t x;
        forever begin
            @(negedge rclk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                x = q.pop_front();
                checks++;
                if (x.cyc < cyc) begin
                    errors++;
                    $display("FAIL %s missed slot cyc=%0d now=%0d", x.nm, x.cyc, cyc);
                end else if (rempty !== x.e || ralmost_empty !== x.ae ||
                             rptr !== x.p || raddr !== x.a || rlevel !== x.l) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got e=%b ae=%b p=%b a=%0d l=%0d want e=%b ae=%b p=%b a=%0d l=%0d",
                             x.nm, cyc, rempty, ralmost_empty, rptr, raddr, rlevel,
                             x.e, x.ae, x.p, x.a, x.l);
                end
            end
        end
    end

    task automatic step(input logic rst, input logic inc, input logic [3:0] w,
                        input string nm, input logic e, input logic ae,
                        input logic [3:0] p, input logic [2:0] a, input logic [3:0] l);
        exp_t x;
        @(negedge rclk);
        rrst = rst;
        rinc = inc;
        wptr = w;
        x.cyc = cyc + 1;
        x.nm  = nm;
        x.e   = e;
        x.ae  = ae;
        x.p   = p;
        x.a   = a;
        x.l   = l;
        q.push_back(x);
    endtask

    logic [3:0] gtab [0:8];

    initial begin
        gtab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                 4'b0111, 4'b0101, 4'b0100, 4'b1100};
        rrst = 1'b1;
        rinc = 1'b0;
        wptr = 4'b0000;

        // reset
        repeat (2) step(1, 0, 4'b0000, "reset", 1, 1, 4'b0000, 3'd0, 4'd0);
        // underflow guard
        repeat (5) step(0, 1, 4'b0000, "underflow", 1, 1, 4'b0000, 3'd0, 4'd0);
        // single write arrives after sync + flag latency
        step(0, 0, 4'b0001, "sync1", 1, 1, 4'b0000, 3'd0, 4'd0);
        step(0, 0, 4'b0001, "sync2", 1, 1, 4'b0000, 3'd0, 4'd0);
        step(0, 0, 4'b0001, "sync3", 0, 1, 4'b0000, 3'd0, 4'd1);
        step(0, 1, 4'b0001, "read1", 1, 1, 4'b0001, 3'd1, 4'd0);
        step(0, 1, 4'b0001, "read1_ign", 1, 1, 4'b0001, 3'd1, 4'd0);

        // full drain of 8 entries with wrap
        step(1, 0, 4'b0000, "reset2", 1, 1, 4'b0000, 3'd0, 4'd0);
        step(0, 0, 4'b1100, "fill_s1", 1, 1, 4'b0000, 3'd0, 4'd0);
        step(0, 0, 4'b1100, "fill_s2", 1, 1, 4'b0000, 3'd0, 4'd0);
        step(0, 0, 4'b1100, "fill_s3", 0, 0, 4'b0000, 3'd0, 4'd8);
        for (int k = 1; k <= 8; k++) begin
            step(0, 1, 4'b1100, $sformatf("drain%0d", k), (k == 8), ((8 - k) <= 2),
                 gtab[k], 3'(k), 4'(8 - k));
        end
        repeat (2) step(0, 1, 4'b1100, "drain_ign", 1, 1, 4'b1100, 3'd0, 4'd0);

        // read coincides with a newer write reaching the synchroniser output
        step(0, 0, 4'b1101, "race_s1", 1, 1, 4'b1100, 3'd0, 4'd0);
        step(0, 0, 4'b1111, "race_s2", 1, 1, 4'b1100, 3'd0, 4'd0);
        step(0, 0, 4'b1111, "race_s3", 0, 1, 4'b1100, 3'd0, 4'd1);
        step(0, 1, 4'b1111, "race_rd", 0, 1, 4'b1101, 3'd1, 4'd1);
        step(0, 1, 4'b1111, "race_rd2", 1, 1, 4'b1111, 3'd2, 4'd0);

        // reset while reading at level 5
        step(0, 0, 4'b1000, "lvl5_s1", 1, 1, 4'b1111, 3'd2, 4'd0);
        step(0, 0, 4'b1000, "lvl5_s2", 1, 1, 4'b1111, 3'd2, 4'd0);
        step(0, 0, 4'b1000, "lvl5_s3", 0, 0, 4'b1111, 3'd2, 4'd5);
        step(1, 1, 4'b0000, "rst_rd", 1, 1, 4'b0000, 3'd0, 4'd0);
        step(0, 0, 4'b0000, "post_rst", 1, 1, 4'b0000, 3'd0, 4'd0);

        repeat (3) @(negedge rclk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue left=%0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
